// File: rtl/timed_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : timed_cmd_sched
//  Purpose  : Timed-command scheduler living beside sample_clk. Commands are
//             queued with a target sample index and released in order once
//             sample_idx reaches the head's stamp. Also sequences time loads
//             into sample_clk so a new sample index takes effect at the next
//             pps edge.
//  Ports    : clk, aresetn (sync, active-low)
//             sample_idx, pps                 - from sample_clk
//             cmd_valid/cmd_ready/cmd_time/cmd_data - command input
//             out_valid/out_ready/out_data/out_late - released command
//             flush                           - discard queue + pending release
//             level, late_count               - status
//             tset_req/tset_value/tset_armed  - time-load request
//             sample_idx_reg(_valid)          - time load to sample_clk
//  Options  : TIMED_CMD_SCHED_LATE_DROP_EN - late heads are silently
//             discarded (still counted) instead of released with out_late.
//  Revision : 1.0 - initial release
// ============================================================================
module timed_cmd_sched #(
    parameter int SAMPLE_CLK_WIDTH = 56,
    parameter int CMD_WIDTH        = 32,
    parameter int DEPTH            = 8
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic [SAMPLE_CLK_WIDTH-1:0] sample_idx,
    input  logic                        pps,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [SAMPLE_CLK_WIDTH-1:0] cmd_time,
    input  logic [CMD_WIDTH-1:0]        cmd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CMD_WIDTH-1:0]        out_data,
    output logic                        out_late,
    input  logic                        flush,
    output logic [$clog2(DEPTH):0]      level,
    output logic [15:0]                 late_count,
    input  logic                        tset_req,
    input  logic [SAMPLE_CLK_WIDTH-1:0] tset_value,
    output logic                        tset_armed,
    output logic [SAMPLE_CLK_WIDTH-1:0] sample_idx_reg,
    output logic                        sample_idx_reg_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] c_DEPTH = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2
    } rel_state_t;

    typedef enum logic [0:0] {
        TS_IDLE  = 1'b0,
        TS_ARMED = 1'b1
    } ts_state_t;

    // ------------------------------------------------------------------
    // Command queue storage
    // ------------------------------------------------------------------
    logic [SAMPLE_CLK_WIDTH-1:0] r_time_mem [DEPTH];
    logic [CMD_WIDTH-1:0]        r_data_mem [DEPTH];
    logic [PW-1:0]               r_wr_ptr;
    logic [PW-1:0]               r_rd_ptr;
    logic [LW-1:0]               r_level;

    rel_state_t                  r_rel_state;
    rel_state_t                  w_rel_next;
    ts_state_t                   r_ts_state;
    ts_state_t                   w_ts_next;

    logic                        w_push;
    logic                        w_pop;
    logic                        w_pop_late;
    logic                        w_issue;
    logic                        w_ts_latch;
    logic                        w_ts_load;

    logic [SAMPLE_CLK_WIDTH-1:0] w_head_time;
    logic [CMD_WIDTH-1:0]        w_head_data;
    logic                        w_head_due;
    logic                        w_head_late;

    logic [CMD_WIDTH-1:0]        r_out_data;
    logic                        r_out_late;
    logic [15:0]                 r_late_count;
    logic [SAMPLE_CLK_WIDTH-1:0] r_ts_value;
    logic [SAMPLE_CLK_WIDTH-1:0] r_sample_idx_reg;
    logic                        r_sample_idx_reg_valid;

    // Reset gating keeps every output low while aresetn is asserted.
    assign cmd_ready = aresetn && (r_level < c_DEPTH) && !flush;
    assign w_push    = cmd_valid && cmd_ready;

    assign w_head_time = r_time_mem[r_rd_ptr];
    assign w_head_data = r_data_mem[r_rd_ptr];
    // Plain unsigned compare; timestamps are assumed never to wrap.
    assign w_head_due  = (sample_idx >= w_head_time);
    assign w_head_late = (sample_idx >  w_head_time);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_time_mem[r_wr_ptr] <= cmd_time;
            r_data_mem[r_wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Release FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!aresetn) r_rel_state <= ST_IDLE;
        else          r_rel_state <= w_rel_next;
    end

    always_comb begin
        w_rel_next = r_rel_state;
        w_pop      = 1'b0;
        w_pop_late = 1'b0;
        w_issue    = 1'b0;
        case (r_rel_state)
            ST_IDLE: begin
                if (r_level != '0) w_rel_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_level == '0) begin
                    w_rel_next = ST_IDLE;
                end else if (w_head_due) begin
                    w_pop      = 1'b1;
                    w_pop_late = w_head_late;
`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
                    // Late heads vanish here; stay in WAIT so the next head
                    // is looked at on the following cycle.
                    w_issue = !w_head_late;
                    if (!w_head_late) w_rel_next = ST_ISSUE;
`else
                    w_issue    = 1'b1;
                    w_rel_next = ST_ISSUE;
`endif
                end
            end
            ST_ISSUE: begin
                if (out_ready) w_rel_next = (r_level != '0) ? ST_WAIT : ST_IDLE;
            end
            default: w_rel_next = ST_IDLE;
        endcase
        if (flush) begin
            w_rel_next = ST_IDLE;
            w_pop      = 1'b0;
            w_pop_late = 1'b0;
            w_issue    = 1'b0;
        end
    end

    // Payload and lateness are captured at pop time and held through ISSUE.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_out_data <= '0;
            r_out_late <= 1'b0;
        end else if (w_issue) begin
            r_out_data <= w_head_data;
`ifdef TIMED_CMD_SCHED_LATE_DROP_EN
            r_out_late <= 1'b0;
`else
            r_out_late <= w_head_late;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn)
            r_late_count <= '0;
        else if (w_pop_late && (r_late_count != 16'hFFFF))
            r_late_count <= r_late_count + 16'd1;
    end

    // ------------------------------------------------------------------
    // Time-set FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!aresetn) r_ts_state <= TS_IDLE;
        else          r_ts_state <= w_ts_next;
    end

    always_comb begin
        w_ts_next  = r_ts_state;
        w_ts_latch = 1'b0;
        w_ts_load  = 1'b0;
        case (r_ts_state)
            TS_IDLE: begin
                // A pps coinciding with the request is ignored: arm only.
                if (tset_req) begin
                    w_ts_latch = 1'b1;
                    w_ts_next  = TS_ARMED;
                end
            end
            TS_ARMED: begin
                w_ts_latch = tset_req;
                if (pps) begin
                    w_ts_load = 1'b1;
                    w_ts_next = TS_IDLE;
                end
            end
            default: w_ts_next = TS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_ts_value             <= '0;
            r_sample_idx_reg       <= '0;
            r_sample_idx_reg_valid <= 1'b0;
        end else begin
            if (w_ts_latch) r_ts_value <= tset_value;
            // A request landing on the pps cycle still wins (last wins).
            if (w_ts_load)  r_sample_idx_reg <= tset_req ? tset_value : r_ts_value;
            r_sample_idx_reg_valid <= w_ts_load;
        end
    end

    assign out_valid            = (r_rel_state == ST_ISSUE);
    assign out_data             = r_out_data;
    assign out_late             = r_out_late;
    assign level                = r_level;
    assign late_count           = r_late_count;
    assign tset_armed           = (r_ts_state == TS_ARMED);
    assign sample_idx_reg       = r_sample_idx_reg;
    assign sample_idx_reg_valid = r_sample_idx_reg_valid;

endmodule
`default_nettype wire

// File: tb/tb_timed_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timed_cmd_sched
//  Purpose  : Directed self-checking bench for timed_cmd_sched.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timed_cmd_sched;

    localparam int SW = 56;
    localparam int CW = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [SW-1:0] sample_idx = '0;
    logic          pps = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [SW-1:0] cmd_time = '0;
    logic [CW-1:0] cmd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_data;
    logic          out_late;
    logic          flush = 1'b0;
    logic [3:0]    level;
    logic [15:0]   late_count;
    logic          tset_req = 1'b0;
    logic [SW-1:0] tset_value = '0;
    logic          tset_armed;
    logic [SW-1:0] sample_idx_reg;
    logic          sample_idx_reg_valid;

    int n_vec = 0;
    int n_err = 0;

    timed_cmd_sched #(.SAMPLE_CLK_WIDTH(SW), .CMD_WIDTH(CW), .DEPTH(DEPTH)) dut (
        .clk(clk), .aresetn(aresetn), .sample_idx(sample_idx), .pps(pps),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_time(cmd_time),
        .cmd_data(cmd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_late(out_late), .flush(flush), .level(level),
        .late_count(late_count), .tset_req(tset_req), .tset_value(tset_value),
        .tset_armed(tset_armed), .sample_idx_reg(sample_idx_reg),
        .sample_idx_reg_valid(sample_idx_reg_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [SW-1:0] t, input logic [CW-1:0] d);
        cmd_valid = 1'b1;
        cmd_time  = t;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (out_valid) ok = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({out_valid, out_late, cmd_ready, tset_armed, sample_idx_reg_valid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {out_valid, out_late, cmd_ready, tset_armed, sample_idx_reg_valid});
        end
        n_vec++;
        if (level !== 4'd0 || late_count !== 16'd0 || out_data !== 32'd0 || sample_idx_reg !== 56'd0) begin
            n_err++;
            $display("FAIL reset_values: level=%0d late_count=%0d out_data=%h sample_idx_reg=%h expected all 0",
                     level, late_count, out_data, sample_idx_reg);
        end
        aresetn = 1'b1;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_ready: got %b expected 1", cmd_ready);
        end
        tick();
    endtask

    task automatic test_single_release();
        bit early = 1'b0;
        out_ready  = 1'b1;
        sample_idx = 56'd900;
        push(56'd1000, 32'hA5A5A5A5);
        for (int v = 901; v <= 1000; v++) begin
            sample_idx = SW'(v);
            tick();
            if (v < 1000 && out_valid) early = 1'b1;
        end
        n_vec++;
        if (early !== 1'b0) begin
            n_err++;
            $display("FAIL single_early: out_valid seen before stamp, got %b expected 0", early);
        end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5A5A5 || out_late !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: valid=%b data=%h late=%b expected 1 a5a5a5a5 0",
                     out_valid, out_data, out_late);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            n_err++;
            $display("FAIL single_after: valid=%b level=%0d expected 0 0", out_valid, level);
        end
    endtask

    task automatic test_order_late();
        bit ok;
        bit spurious = 1'b0;
        out_ready  = 1'b1;
        sample_idx = 56'd450;
        push(56'd500, 32'h0000_0001);
        push(56'd400, 32'h0000_0002);
        push(56'd600, 32'h0000_0003);
        sample_idx = 56'd500;
        wait_valid(10, ok);
        n_vec++;
        if (!ok || out_data !== 32'h1 || out_late !== 1'b0) begin
            n_err++;
            $display("FAIL order_first: ok=%b data=%h late=%b expected 1 00000001 0", ok, out_data, out_late);
        end
        tick();
`ifndef TIMED_CMD_SCHED_LATE_DROP_EN
        wait_valid(10, ok);
        n_vec++;
        if (!ok || out_data !== 32'h2 || out_late !== 1'b1) begin
            n_err++;
            $display("FAIL order_late: ok=%b data=%h late=%b expected 1 00000002 1", ok, out_data, out_late);
        end
        tick();
`endif
        for (int i = 0; i < 5; i++) begin
            if (out_valid) spurious = 1'b1;
            tick();
        end
        n_vec++;
        if (spurious !== 1'b0) begin
            n_err++;
            $display("FAIL order_gap: out_valid before 600 got %b expected 0", spurious);
        end
        sample_idx = 56'd600;
        wait_valid(10, ok);
        n_vec++;
        if (!ok || out_data !== 32'h3 || out_late !== 1'b0) begin
            n_err++;
            $display("FAIL order_third: ok=%b data=%h late=%b expected 1 00000003 0", ok, out_data, out_late);
        end
        tick();
        n_vec++;
        if (late_count !== 16'd1 || level !== 4'd0) begin
            n_err++;
            $display("FAIL order_count: late_count=%0d level=%0d expected 1 0", late_count, level);
        end
    endtask

    task automatic test_full_flush();
        sample_idx = 56'd0;
        for (int i = 0; i < DEPTH; i++)
            push(56'h00F0_0000_0000_0000 + SW'(i), 32'hC000_0000 + CW'(i));
        n_vec++;
        if (level !== 4'd8 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_state: level=%0d ready=%b expected 8 0", level, cmd_ready);
        end
        push(56'h00F0_0000_0000_00FF, 32'hC000_00FF);
        n_vec++;
        if (level !== 4'd8) begin
            n_err++;
            $display("FAIL full_no_overwrite: level=%0d expected 8", level);
        end
        cmd_valid = 1'b1;
        flush     = 1'b1;
        #1;
        n_vec++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ready_low: ready=%b expected 0", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        flush     = 1'b0;
        #1;
        n_vec++;
        if (level !== 4'd0 || cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_result: level=%0d ready=%b valid=%b expected 0 1 0", level, cmd_ready, out_valid);
        end
        tick();
    endtask

    task automatic test_back_pressure();
        bit ok;
        bit unstable = 1'b0;
        out_ready  = 1'b0;
        sample_idx = 56'd100;
        push(56'd200, 32'hDEAD0001);
        push(56'd200, 32'hDEAD0002);
        sample_idx = 56'd200;
        wait_valid(10, ok);
        n_vec++;
        if (!ok || out_data !== 32'hDEAD0001 || out_late !== 1'b0) begin
            n_err++;
            $display("FAIL bp_first: ok=%b data=%h late=%b expected 1 dead0001 0", ok, out_data, out_late);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== 32'hDEAD0001 || out_late !== 1'b0 || level !== 4'd1)
                unstable = 1'b1;
        end
        n_vec++;
        if (unstable !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold: unstable=%b expected 0 (valid=%b data=%h level=%0d)",
                     unstable, out_valid, out_data, level);
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_spacing: valid=%b expected 0", out_valid);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEAD0002) begin
            n_err++;
            $display("FAIL bp_second: valid=%b data=%h expected 1 dead0002", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_time_set();
        bit early = 1'b0;
        tset_req   = 1'b1;
        tset_value = 56'h55555555555555;
        tick();
        tset_req = 1'b0;
        n_vec++;
        if (tset_armed !== 1'b1 || sample_idx_reg_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ts_arm: armed=%b valid=%b expected 1 0", tset_armed, sample_idx_reg_valid);
        end
        for (int i = 0; i < 999; i++) begin
            tick();
            if (sample_idx_reg_valid) early = 1'b1;
        end
        pps = 1'b1;
        tick();
        pps = 1'b0;
        n_vec++;
        if (early || sample_idx_reg_valid !== 1'b1 || sample_idx_reg !== 56'h55555555555555 || tset_armed !== 1'b0) begin
            n_err++;
            $display("FAIL ts_load: early=%b valid=%b reg=%h armed=%b expected 0 1 55555555555555 0",
                     early, sample_idx_reg_valid, sample_idx_reg, tset_armed);
        end
        tick();
        n_vec++;
        if (sample_idx_reg_valid !== 1'b0 || sample_idx_reg !== 56'h55555555555555) begin
            n_err++;
            $display("FAIL ts_hold: valid=%b reg=%h expected 0 55555555555555", sample_idx_reg_valid, sample_idx_reg);
        end
        tset_req   = 1'b1;
        tset_value = 56'h0123456789ABCD;
        tick();
        tset_value = 56'hFEDCBA98765432;
        tick();
        tset_req = 1'b0;
        tick();
        pps = 1'b1;
        tick();
        pps = 1'b0;
        n_vec++;
        if (sample_idx_reg_valid !== 1'b1 || sample_idx_reg !== 56'hFEDCBA98765432) begin
            n_err++;
            $display("FAIL ts_last_wins: valid=%b reg=%h expected 1 fedcba98765432", sample_idx_reg_valid, sample_idx_reg);
        end
        tick();
        tset_req   = 1'b1;
        pps        = 1'b1;
        tset_value = 56'h00000000001234;
        tick();
        tset_req = 1'b0;
        pps      = 1'b0;
        n_vec++;
        if (tset_armed !== 1'b1 || sample_idx_reg_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ts_same_cycle: armed=%b valid=%b expected 1 0", tset_armed, sample_idx_reg_valid);
        end
        tick();
        pps = 1'b1;
        tick();
        pps = 1'b0;
        n_vec++;
        if (sample_idx_reg_valid !== 1'b1 || sample_idx_reg !== 56'h00000000001234) begin
            n_err++;
            $display("FAIL ts_next_pps: valid=%b reg=%h expected 1 00000000001234", sample_idx_reg_valid, sample_idx_reg);
        end
        tick();
    endtask

    task automatic test_reset_in_issue();
        bit ok;
        bit stale = 1'b0;
        out_ready  = 1'b0;
        sample_idx = 56'd1000;
        push(56'd1000, 32'hE0000001);
        push(56'h00F0_0000_0000_0000, 32'hE0000002);
        push(56'h00F0_0000_0000_0000, 32'hE0000003);
        push(56'h00F0_0000_0000_0000, 32'hE0000004);
        tset_req   = 1'b1;
        tset_value = 56'h00000000ABCDEF;
        wait_valid(10, ok);
        tset_req = 1'b0;
        n_vec++;
        if (!ok || level !== 4'd3 || out_data !== 32'hE0000001) begin
            n_err++;
            $display("FAIL rst_setup: ok=%b level=%0d data=%h expected 1 3 e0000001", ok, level, out_data);
        end
        tick();
        aresetn = 1'b0;
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || level !== 4'd0 || tset_armed !== 1'b0 || late_count !== 16'd0) begin
            n_err++;
            $display("FAIL rst_issue: valid=%b level=%0d armed=%b late_count=%0d expected 0 0 0 0",
                     out_valid, level, tset_armed, late_count);
        end
        aresetn   = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid || level != 4'd0) stale = 1'b1;
        end
        n_vec++;
        if (stale !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_stale: stale=%b expected 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_single_release();
        test_order_late();
        test_full_flush();
        test_back_pressure();
        test_time_set();
        test_reset_in_issue();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
